// File: rtl/gpu_pkg.sv
// Shared core/fetcher encodings for the GPU front end.
package gpu_pkg;

  localparam logic [2:0] CoreFetch  = 3'b001;
  localparam logic [2:0] CoreDecode = 3'b010;

  typedef enum logic [2:0] {
    FetchIdle     = 3'b000,
    FetchFetching = 3'b001,
    FetchFetched  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/coalescing_fetcher_if.sv
// Program-memory read channel: valid/address out, ready/data back in the same cycle.
interface coalescing_fetcher_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16
) ();

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );

endinterface

// File: rtl/thread_priority_encoder.sv
// Lowest-index-wins priority encoder used to pick the fetch leader thread.
module thread_priority_encoder #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coalescing_fetcher.sv
// Per-warp instruction fetcher: one memory read per distinct PC, result broadcast
// to every active thread sharing that PC.
module coalescing_fetcher
  import gpu_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned THREADS_PER_BLOCK     = 4,
  localparam int unsigned CntW = $clog2(THREADS_PER_BLOCK + 1)
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [2:0]                                            core_state,
  input  logic [THREADS_PER_BLOCK-1:0]                          thread_mask,
  input  logic [THREADS_PER_BLOCK-1:0][PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  coalescing_fetcher_if.master                                  mem_bus,
  output logic [2:0]                                            fetcher_state,
  output logic [THREADS_PER_BLOCK-1:0][PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [THREADS_PER_BLOCK-1:0]                          instruction_valid,
  output logic [CntW-1:0]                                       fetch_count
);

  localparam int unsigned T    = THREADS_PER_BLOCK;
  localparam int unsigned IdxW = (T > 1) ? $clog2(T) : 1;

  fetcher_state_e                                state_q;
  logic                                          req_valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]              addr_q;
  logic [T-1:0][PROGRAM_MEM_DATA_BITS-1:0]       instr_q;
  logic [T-1:0]                                  ivalid_q;
  logic [CntW-1:0]                               count_q;
  logic [T-1:0][PROGRAM_MEM_ADDR_BITS-1:0]       pc_q;
  logic [T-1:0]                                  mask_q;

  logic [T-1:0]    hit;
  logic [T-1:0]    pending;
  logic [IdxW-1:0] leader_idx;
  logic            leader_valid;

  // Threads served by this cycle's completion are excluded so the next leader
  // can be issued on the same edge.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(T); i++) begin
      hit[i] = req_valid_q && mem_bus.mem_read_ready && mask_q[i] && (pc_q[i] == addr_q);
    end
    pending = mask_q & ~ivalid_q & ~hit;
  end

  thread_priority_encoder #(
    .NumReq (T)
  ) u_leader_enc (
    .req_i   (pending),
    .idx_o   (leader_idx),
    .valid_o (leader_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FetchIdle;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      ivalid_q    <= '0;
      count_q     <= '0;
      pc_q        <= '0;
      mask_q      <= '0;
    end else begin
      case (state_q)
        FetchIdle: begin
          if (core_state == CoreFetch) begin
            pc_q     <= current_pc;
            mask_q   <= thread_mask;
            ivalid_q <= '0;
            count_q  <= '0;
            state_q  <= FetchFetching;
          end
        end
        FetchFetching: begin
          if (!req_valid_q || mem_bus.mem_read_ready) begin
            for (int i = 0; i < int'(T); i++) begin
              if (hit[i]) instr_q[i] <= mem_bus.mem_read_data;
            end
            ivalid_q <= ivalid_q | hit;
            if (leader_valid) begin
              req_valid_q <= 1'b1;
              addr_q      <= pc_q[leader_idx];
              count_q     <= count_q + CntW'(1);
            end else begin
              req_valid_q <= 1'b0;
              state_q     <= FetchFetched;
            end
          end
        end
        FetchFetched: begin
          if (core_state == CoreDecode) state_q <= FetchIdle;
        end
        default: begin
          state_q     <= FetchIdle;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_bus.mem_read_valid   = req_valid_q;
  assign mem_bus.mem_read_address = addr_q;
  assign fetcher_state            = state_q;
  assign instruction              = instr_q;
  assign instruction_valid        = ivalid_q;
  assign fetch_count              = count_q;

endmodule

// File: tb/tb_coalescing_fetcher.sv
// Directed self-checking bench for coalescing_fetcher (T=4, 8-bit PC, 16-bit instr).
module tb_coalescing_fetcher;
  import gpu_pkg::*;

  logic             clk;
  logic             reset;
  logic [2:0]       core_state;
  logic [3:0]       thread_mask;
  logic [3:0][7:0]  current_pc;
  logic [2:0]       fetcher_state;
  logic [3:0][15:0] instruction;
  logic [3:0]       instruction_valid;
  logic [2:0]       fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  coalescing_fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) mem_if ();

  coalescing_fetcher #(
    .PROGRAM_MEM_ADDR_BITS (8),
    .PROGRAM_MEM_DATA_BITS (16),
    .THREADS_PER_BLOCK     (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .core_state        (core_state),
    .thread_mask       (thread_mask),
    .current_pc        (current_pc),
    .mem_bus           (mem_if),
    .fetcher_state     (fetcher_state),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .fetch_count       (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [3:0] mask, input logic [3:0][7:0] pcs);
    thread_mask = mask;
    current_pc  = pcs;
    core_state  = CoreFetch;
    tick();
    core_state  = 3'b000;
    check("enter_fetching", 64'(fetcher_state), 64'(FetchFetching));
  endtask

  // Wait (bounded) for a request, hold it `delay` cycles, then complete it.
  task automatic serve(input int delay, input logic [15:0] data, output logic [7:0] addr);
    int waited;
    waited = 0;
    while (!mem_if.mem_read_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("req_seen", 64'(mem_if.mem_read_valid), 64'(1));
    addr = mem_if.mem_read_address;
    for (int d = 0; d < delay; d++) begin
      tick();
      check("addr_hold", {55'(0), mem_if.mem_read_valid, mem_if.mem_read_address},
            {55'(0), 1'b1, addr});
    end
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = data;
    tick();
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(fetcher_state), 64'(FetchIdle));
    check({tag, "_valid"}, 64'(mem_if.mem_read_valid), 64'(0));
    check({tag, "_addr"}, 64'(mem_if.mem_read_address), 64'(0));
    check({tag, "_instr"}, instruction, 64'(0));
    check({tag, "_ivalid"}, 64'(instruction_valid), 64'(0));
    check({tag, "_count"}, 64'(fetch_count), 64'(0));
  endtask

  task automatic decode_to_idle(input string tag);
    core_state = CoreDecode;
    tick();
    core_state = 3'b000;
    check(tag, 64'(fetcher_state), 64'(FetchIdle));
  endtask

  initial begin
    logic [7:0]       a;
    logic [63:0]      snap;

    reset                 = 1'b0;
    core_state            = 3'b000;
    thread_mask           = '0;
    current_pc            = '0;
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data  = '0;
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    tick();
    check("idle_hold", 64'(fetcher_state), 64'(FetchIdle));

    // All threads on one PC: a single coalesced read.
    start_fetch(4'b1111, {8'h10, 8'h10, 8'h10, 8'h10});
    serve(0, 16'hABCD, a);
    check("t1_addr", 64'(a), 64'h10);
    check("t1_state", 64'(fetcher_state), 64'(FetchFetched));
    check("t1_valid_low", 64'(mem_if.mem_read_valid), 64'(0));
    check("t1_instr", instruction, 64'hABCD_ABCD_ABCD_ABCD);
    check("t1_ivalid", 64'(instruction_valid), 64'hF);
    check("t1_count", 64'(fetch_count), 64'(1));
    decode_to_idle("t1_decode");

    // Four distinct PCs, each ready delayed two cycles.
    start_fetch(4'b1111, {8'h03, 8'h02, 8'h01, 8'h00});
    for (int i = 0; i < 4; i++) begin
      serve(2, 16'h1000 + 16'(i), a);
      check("t2_addr", 64'(a), 64'(i));
    end
    check("t2_state", 64'(fetcher_state), 64'(FetchFetched));
    check("t2_count", 64'(fetch_count), 64'(4));
    check("t2_instr", instruction, 64'h1003_1002_1001_1000);
    check("t2_ivalid", 64'(instruction_valid), 64'hF);
    decode_to_idle("t2_decode");

    // Partial mask; inputs changed after latch must not matter.
    start_fetch(4'b0101, {8'h22, 8'h20, 8'h21, 8'h20});
    thread_mask = 4'b1111;
    current_pc  = {8'h77, 8'h66, 8'h55, 8'h44};
    serve(1, 16'hBEEF, a);
    check("t3_addr", 64'(a), 64'h20);
    check("t3_state", 64'(fetcher_state), 64'(FetchFetched));
    check("t3_count", 64'(fetch_count), 64'(1));
    check("t3_ivalid", 64'(instruction_valid), 64'h5);
    check("t3_instr", instruction, 64'h1003_BEEF_1001_BEEF);
    decode_to_idle("t3_decode");

    // Empty mask: IDLE -> FETCHING -> FETCHED with no request.
    thread_mask = 4'b0000;
    core_state  = CoreFetch;
    tick();
    check("t4_fetching", 64'(fetcher_state), 64'(FetchFetching));
    check("t4_valid0", 64'(mem_if.mem_read_valid), 64'(0));
    tick();
    check("t4_fetched", 64'(fetcher_state), 64'(FetchFetched));
    check("t4_valid1", 64'(mem_if.mem_read_valid), 64'(0));
    check("t4_count", 64'(fetch_count), 64'(0));
    check("t4_ivalid", 64'(instruction_valid), 64'(0));

    // FETCHED holds with core_state still FETCH.
    snap = instruction;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_state", 64'(fetcher_state), 64'(FetchFetched));
      check("t5_instr", instruction, snap);
      check("t5_valid", 64'(mem_if.mem_read_valid), 64'(0));
    end
    decode_to_idle("t5_decode");

    // Reset during the second outstanding read, with a coincident ready.
    start_fetch(4'b1111, {8'h33, 8'h32, 8'h31, 8'h30});
    serve(0, 16'h1111, a);
    check("t6_addr0", 64'(a), 64'h30);
    check("t6_req2", {55'(0), mem_if.mem_read_valid, mem_if.mem_read_address},
          {55'(0), 1'b1, 8'h31});
    tick();
    check("t6_req2_hold", 64'(mem_if.mem_read_address), 64'h31);
    reset                 = 1'b0;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = 16'hDEAD;
    tick();
    check_reset_outputs("t6_rst");
    reset = 1'b1;
    tick();
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data  = '0;
    check_reset_outputs("t6_late");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
